// File: rtl/parser_defs.sv
// Shared record layout for parsed market messages (128 bits).
package parser_defs;
    typedef struct packed {
        logic [7:0]  msg_type;
        logic [7:0]  side;
        logic [15:0] stock_id;
        logic [31:0] order_id;
        logic [31:0] price;
        logic [31:0] quantity;
    } parsed_msg_t;
endpackage

// File: rtl/msg_fifo_mc.sv
// Multi-channel message FIFO: steers writes by stock_id low bits into per-channel
// queues and drains them round-robin through a first-word-fall-through port.
module msg_fifo_mc
    import parser_defs::*;
#(
    parameter int NUM_CH       = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_THRESH = FIFO_DEPTH - 2,
    localparam int CHW         = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  parsed_msg_t       msg_in,
    input  logic              read_en,
    output parsed_msg_t       msg_out,
    output logic              msg_valid,
    output logic [CHW-1:0]    msg_ch,
    output logic [NUM_CH-1:0] full,
    output logic [NUM_CH-1:0] almost_full,
    output logic [NUM_CH-1:0] empty,
    output logic [15:0]       drop_count,
    output logic              overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    parsed_msg_t    mem    [NUM_CH][FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr [NUM_CH];
    logic [AW-1:0]  rd_ptr [NUM_CH];
    logic [CW-1:0]  count  [NUM_CH];
    logic [CHW-1:0] rr;
    logic [CHW-1:0] sel;
    logic [CHW-1:0] idx;
    logic [CHW-1:0] wch;
    logic           found;
    logic           wr_ok;
    logic           drop;
    logic           pop;
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] pop_hit;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            full[c]        = (count[c] == CW'(FIFO_DEPTH));
            almost_full[c] = (count[c] >= CW'(AFULL_THRESH));
            empty[c]       = (count[c] == '0);
        end
    end

    // Round-robin pick: first non-empty channel starting at rr.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = rr + CHW'(i);
            if (!found && !empty[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Handshake: msg_valid/msg_out/msg_ch depend only on registered state; a
    // transfer happens on any edge where msg_valid=1 and read_en=1, and read_en
    // with msg_valid=0 has no effect.
    assign msg_valid = found;
    assign msg_ch    = found ? sel : '0;
    assign msg_out   = found ? mem[sel][rd_ptr[sel]] : '0;

    assign wch   = msg_in.stock_id[CHW-1:0];
    assign wr_ok = write_en && !full[wch];
    assign drop  = write_en && full[wch];
    assign pop   = read_en && found;

    always_comb begin
        wr_hit  = '0;
        pop_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_hit[c]  = wr_ok && (wch == CHW'(c));
            pop_hit[c] = pop && (sel == CHW'(c));
        end
    end

    // Storage is never cleared; masking on msg_valid hides stale entries.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[wch][wr_ptr[wch]] <= msg_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
            rr         <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_hit[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + AW'(1);
                end
                if (pop_hit[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + AW'(1);
                end
                if (wr_hit[c] && !pop_hit[c]) begin
                    count[c] <= count[c] + CW'(1);
                end else if (!wr_hit[c] && pop_hit[c]) begin
                    count[c] <= count[c] - CW'(1);
                end
            end
            if (pop) begin
                rr <= sel + CHW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_msg_fifo_mc.sv
// Directed bench for msg_fifo_mc with a scoreboard of expected {channel, message} pops.
module tb_msg_fifo_mc;
    import parser_defs::*;

    localparam int W = 128 + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_en;
    parsed_msg_t msg_in;
    logic        read_en;
    parsed_msg_t msg_out;
    logic        msg_valid;
    logic [1:0]  msg_ch;
    logic [3:0]  full;
    logic [3:0]  almost_full;
    logic [3:0]  empty;
    logic [15:0] drop_count;
    logic        overflow;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    msg_fifo_mc #(.NUM_CH(4), .FIFO_DEPTH(4), .AFULL_THRESH(3)) dut (
        .clk(clk), .reset(reset), .write_en(write_en), .msg_in(msg_in),
        .read_en(read_en), .msg_out(msg_out), .msg_valid(msg_valid),
        .msg_ch(msg_ch), .full(full), .almost_full(almost_full), .empty(empty),
        .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_empty"}, empty, 4'b1111);
        check({tag, "_full"}, full, 4'b0000);
        check({tag, "_afull"}, almost_full, 4'b0000);
        check({tag, "_valid"}, msg_valid, 1'b0);
        check({tag, "_out"}, msg_out, 128'd0);
        check({tag, "_ch"}, msg_ch, 2'd0);
        check({tag, "_drops"}, drop_count, 16'd0);
        check({tag, "_ovf"}, overflow, 1'b0);
    endtask

    function automatic parsed_msg_t make_msg(input logic [15:0] sid, input logic [31:0] oid);
        parsed_msg_t m;
        m          = '0;
        m.msg_type = 8'(($urandom_range(0, 255)));
        m.side     = 8'($urandom_range(0, 1));
        m.stock_id = sid;
        m.order_id = oid;
        m.price    = $urandom;
        m.quantity = $urandom;
        return m;
    endfunction

    // Writes one message; push=1 records it as an expected future pop.
    task automatic wr(input logic [15:0] sid, input logic [31:0] oid, input bit push);
        parsed_msg_t m;
        m        = make_msg(sid, oid);
        msg_in   = m;
        write_en = 1'b1;
        if (push) exp_q.push_back({sid[1:0], m});
        tick();
        write_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        read_en = 1'b1;
        while (exp_q.size() > 0 && guard < 40) begin
            check({tag, "_valid"}, msg_valid, 1'b1);
            if (msg_valid) check({tag, "_data"}, {msg_ch, msg_out}, exp_q.pop_front());
            tick();
            guard++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $error("FAIL %s_timeout: got %0d pending want 0", tag, exp_q.size());
            exp_q.delete();
        end
        read_en = 1'b0;
    endtask

    initial begin
        parsed_msg_t m;
        reset    = 1'b1;
        write_en = 1'b0;
        read_en  = 1'b0;
        msg_in   = '0;

        // 1. reset
        do_reset(2);
        check_reset_vals("rst");

        // 2. ordering on ch0
        wr(16'h0010, 32'h1000, 1'b1);
        check("ord_vis", msg_valid, 1'b1);
        wr(16'h0014, 32'h1001, 1'b1);
        wr(16'h0018, 32'h1002, 1'b1);
        drain("ord");
        check("ord_empty0", empty[0], 1'b1);

        // 3. full / overflow on ch1
        wr(16'h0011, 32'h2000, 1'b1);
        wr(16'h0011, 32'h2001, 1'b1);
        check("full_af_2", almost_full[1], 1'b0);
        wr(16'h0011, 32'h2002, 1'b1);
        check("full_af_3", almost_full[1], 1'b1);
        check("full_f_3", full[1], 1'b0);
        wr(16'h0011, 32'h2003, 1'b1);
        check("full_f_4", full[1], 1'b1);
        check("full_drops_4", drop_count, 16'd0);
        wr(16'h0011, 32'h2004, 1'b0);
        check("full_drops_5", drop_count, 16'd1);
        check("full_ovf_5", overflow, 1'b1);
        drain("full_rd");
        check("full_rd_end", msg_valid, 1'b0);

        // 4. round robin from a fresh arbiter pointer
        do_reset(1);
        wr(16'h0020, 32'h3000, 1'b0);
        wr(16'h0021, 32'h3001, 1'b0);
        wr(16'h0022, 32'h3002, 1'b0);
        wr(16'h0023, 32'h3003, 1'b0);
        wr(16'h0024, 32'h3004, 1'b0);
        check("rr_empty", empty, 4'b0000);
        read_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("rr_ch", msg_ch, (i == 4) ? 2'd0 : 2'(i));
            check("rr_oid", msg_out.order_id, 32'h3000 + 32'(i));
            tick();
        end
        read_en = 1'b0;
        check("rr_end", msg_valid, 1'b0);

        // 5a. same-cycle write and pop on ch2 holding 2 entries
        wr(16'h0032, 32'h4000, 1'b1);
        wr(16'h0036, 32'h4001, 1'b1);
        m        = make_msg(16'h003A, 32'h4002);
        msg_in   = m;
        write_en = 1'b1;
        read_en  = 1'b1;
        check("sim2_head", {msg_ch, msg_out}, exp_q.pop_front());
        exp_q.push_back({2'd2, m});
        tick();
        write_en = 1'b0;
        read_en  = 1'b0;
        check("sim2_af", almost_full[2], 1'b0);
        check("sim2_empty", empty[2], 1'b0);
        drain("sim2");
        check("sim2_end", msg_valid, 1'b0);

        // 5b. write to full ch3 while it is popped
        wr(16'h0043, 32'h5000, 1'b1);
        wr(16'h0047, 32'h5001, 1'b1);
        wr(16'h004B, 32'h5002, 1'b1);
        wr(16'h004F, 32'h5003, 1'b1);
        check("sim3_full", full[3], 1'b1);
        msg_in   = make_msg(16'h0053, 32'h5004);
        write_en = 1'b1;
        read_en  = 1'b1;
        check("sim3_head", {msg_ch, msg_out}, exp_q.pop_front());
        tick();
        write_en = 1'b0;
        read_en  = 1'b0;
        check("sim3_full_after", full[3], 1'b0);
        check("sim3_af_after", almost_full[3], 1'b1);
        check("sim3_drops", drop_count, 16'd1);
        check("sim3_ovf", overflow, 1'b1);
        drain("sim3");
        check("sim3_end", msg_valid, 1'b0);

        // 6. reset in the middle of traffic
        wr(16'h0062, 32'h6000, 1'b1);
        wr(16'h0066, 32'h6001, 1'b0);
        wr(16'h006A, 32'h6002, 1'b0);
        wr(16'h006E, 32'h6003, 1'b0);
        wr(16'h0072, 32'h6004, 1'b0);
        drain("mid_pop");
        check("mid_drops", drop_count, 16'd2);
        check("mid_af", almost_full[2], 1'b1);
        check("mid_full", full[2], 1'b0);
        do_reset(1);
        check_reset_vals("mid_rst");
        wr(16'h0076, 32'h7000, 1'b1);
        check("post_empty", empty, 4'b1011);
        check("post_ch", msg_ch, 2'd2);
        drain("post");
        check("post_end", msg_valid, 1'b0);
        check("post_q", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/msg_fifo_mc.md
# msg_fifo_mc

Multi-channel successor to the single-queue message FIFO. It accepts `parsed_msg_t` records from the parser and steers each one into a per-channel queue chosen by the low bits of `stock_id`. A round-robin arbiter then presents the queue heads to the downstream consumer through a first-word-fall-through interface. The block adds per-channel full and almost-full flags, plus drop accounting for writes to full channels; the single FIFO had neither.

## Interface
- `NUM_CH`, default 4: number of channels. Power of 2, ≥ 2. `CHW = $clog2(NUM_CH)`.
- `FIFO_DEPTH`, default 16: entries per channel. Power of 2, ≥ 2.
- `AFULL_THRESH`, default `FIFO_DEPTH-2`: almost-full level. Range 1..`FIFO_DEPTH`.
- `clk`  in  1  single clock; everything updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `write_en`  in  1  write `msg_in` this cycle.
- `msg_in`  in  `parsed_msg_t` (128 bits, from `parser_defs.sv`)  message to enqueue.
- `read_en`  in  1  pop the presented message. It has effect only when `msg_valid` = 1.
- `msg_out`  out  `parsed_msg_t`  head of the selected channel. Equals `'0` when `msg_valid` = 0.
- `msg_valid`  out  1  at least one channel is non-empty.
- `msg_ch`  out  `CHW`  channel that `msg_out` came from. Equals 0 when `msg_valid` = 0.
- `full`  out  `NUM_CH`  bit c is 1 when count[c] == `FIFO_DEPTH`.
- `almost_full`  out  `NUM_CH`  bit c is 1 when count[c] ≥ `AFULL_THRESH`.
- `empty`  out  `NUM_CH`  bit c is 1 when count[c] == 0.
- `drop_count`  out  16  number of dropped writes, saturating at 16'hFFFF.
- `overflow`  out  1  sticky; set by the first dropped write and cleared only by reset.

## Operation
- **Per-channel state.** Each channel has its own storage, `wr_ptr`, `rd_ptr` (each `$clog2(FIFO_DEPTH)` bits) and `count` (`$clog2(FIFO_DEPTH)+1` bits). Pointers wrap modulo `FIFO_DEPTH`.
- **Write steering.** Target channel `wch = msg_in.stock_id[CHW-1:0]`.
- **Write accept/drop.** When `write_en` = 1 and `full[wch]` = 0 (pre-edge value):
  - store `msg_in` at `wr_ptr[wch]`;
  - increment `wr_ptr[wch]`.
- When `write_en` = 1 and `full[wch]` = 1:
  - drop the write;
  - increment `drop_count` unless it is already 16'hFFFF;
  - set `overflow`.
- **Arbiter.** Register `rr` is `CHW` bits. The selected channel `sel` is the first non-empty channel in the order rr, rr+1, … rr+NUM_CH-1 (mod NUM_CH).
- **Output decode.** `msg_valid`, `msg_out` and `msg_ch` are combinational functions of registered state (counts, pointers, storage, rr). They have no path from `write_en`, `read_en` or `msg_in`.
- **Pop.** When `read_en` = 1 and `msg_valid` = 1:
  - increment `rd_ptr[sel]`;
  - set `rr` to `sel+1` (mod NUM_CH).
- When no pop occurs, `rr` holds.
- **Count update.**
  - count[c] increments on an accepted write to c with no pop from c.
  - count[c] decrements on a pop from c with no accepted write to c.
  - count[c] is unchanged when both happen, or neither.
- **Same-cycle write and pop on one channel.** Both take effect, and FIFO order is preserved.
- **Write to a full channel while it is popped.** The write is dropped, because `full` is evaluated before the edge. The pop still happens.
- **`read_en` while `msg_valid` = 0.** Ignored; no state changes.
- **Reset.** While `reset` = 1 at an edge:
  - all counts, pointers, `rr`, `drop_count` and `overflow` go to 0;
  - writes and reads in that cycle are ignored.
- **Storage contents.** Storage RAM need not be cleared. `msg_out` is masked to `'0` while `msg_valid` = 0.

## Timing
- **Reset values** (cycle after the reset edge):
  - `empty` = all 1s;
  - `full` = 0;
  - `almost_full` = 0;
  - `msg_valid` = 0, `msg_out` = `'0`, `msg_ch` = 0;
  - `drop_count` = 0, `overflow` = 0.
- **Write-to-visible latency is 1 cycle.** A write accepted at edge k is reflected in `empty`, `msg_valid` and `msg_out` during cycle k+1.
- **Pop latency is 0 cycles to the data.** Data is valid in the same cycle `read_en` is sampled. The next head or channel appears after the popping edge.
- **Flags.** `full`, `almost_full`, `empty`, `drop_count` and `overflow` all update on the edge of the causing event.
- **Throughput.** One write and one pop per cycle, sustained, on any mix of channels.

## Test plan
Bench parameters for all scenarios: NUM_CH=4, FIFO_DEPTH=4, AFULL_THRESH=3.

1. **Reset.** Hold reset for 2 cycles → `empty`=4'b1111, `full`=0, `msg_valid`=0, `msg_out`=0, `drop_count`=0.
2. **Ordering.** Write stock_id 8'h10, 8'h14, 8'h18 (all ch0), with order_id 32'h1000..32'h1002. Hold `read_en`=1 → pops occur in order 1000, 1001, 1002, all with `msg_ch`=0. `empty[0]`=1 after the third pop.
3. **Full and overflow.** Write 5 messages to ch1 (stock_id 8'h11) with no reads:
   - `almost_full[1]`=1 after the 3rd write;
   - `full[1]`=1 after the 4th write;
   - the 5th write is dropped: `drop_count`=1, `overflow`=1;
   - reading back returns exactly 4 messages.
4. **Round robin.** Load one message into each of ch0..ch3 plus a second message into ch0, then hold `read_en`=1 → `msg_ch` sequence is 0, 1, 2, 3, 0, then `msg_valid`=0.
5. **Simultaneous events.**
   - ch2 holds 2 entries; write to ch2 and pop it in the same cycle → count stays 2 and the order is preserved.
   - ch3 is full; write to ch3 and pop it in the same cycle → the write is dropped, count becomes 3, `drop_count` increments.
6. **Reset mid-operation.** ch2 holds 3 entries and `drop_count`=2. Pulse reset for 1 cycle → all flags return to their reset values. A write on the next cycle is visible 1 cycle later with `msg_ch`=2.
